// File: rtl/timer_run_ctrl_if.sv
// timer_run_ctrl_if: key/timer control bundle between the debounced keys,
// the timer datapath and timer_run_ctrl.
//   master : drives the key levels, tick and terminal decode (board/bench side)
//   slave  : the run controller, drives load/enable/direction/done/alarm/state
interface timer_run_ctrl_if;
    logic       start_stop_i;
    logic       clear_i;
    logic       dir_up_i;
    logic       tick_i;
    logic       term_i;
    logic       timer_load_o;
    logic       timer_en_o;
    logic       timer_up_o;
    logic       done_o;
    logic       alarm_o;
    logic [2:0] state_o;

    modport master (
        output start_stop_i, clear_i, dir_up_i, tick_i, term_i,
        input  timer_load_o, timer_en_o, timer_up_o, done_o, alarm_o, state_o
    );

    modport slave (
        input  start_stop_i, clear_i, dir_up_i, tick_i, term_i,
        output timer_load_o, timer_en_o, timer_up_o, done_o, alarm_o, state_o
    );
endinterface

// File: rtl/timer_run_ctrl.sv
// timer_run_ctrl: run/pause/alarm sequencer for the BCD up/down timer.
// Turns debounced start/stop and clear keys into timer load, enable and
// direction, detects terminal count and blinks an alarm after expiry.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - timer_run_ctrl_if.slave: key levels, dir switch, tick, term in;
//          timer_load_o/timer_en_o/timer_up_o/done_o/alarm_o/state_o out
module timer_run_ctrl #(
    parameter int BLINK_TICKS   = 4,  // ticks between alarm toggles (>=1)
    parameter int ALARM_TOGGLES = 8   // toggles before alarm held low (even, >=2)
) (
    input  logic                 clk,
    input  logic                 rst,
    timer_run_ctrl_if.slave      bus
);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam int TW = $clog2(ALARM_TOGGLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4,
        CLR   = 3'd5
    } state_t;

    state_t        state;
    logic          start_q, clear_q;
    logic          up_q, alarm_q;
    logic [BW-1:0] blink_cnt;
    logic [TW-1:0] tog_cnt;

    // Key history resets to "pressed" so a key held through reset only
    // counts once it has been released and pressed again.
    logic start_p, clear_p;
    assign start_p = bus.start_stop_i & ~start_q;
    assign clear_p = bus.clear_i & ~clear_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            start_q   <= 1'b1;
            clear_q   <= 1'b1;
            up_q      <= 1'b0;
            alarm_q   <= 1'b0;
            blink_cnt <= '0;
            tog_cnt   <= '0;
        end else begin
            start_q <= bus.start_stop_i;
            clear_q <= bus.clear_i;
            case (state)
                IDLE: begin
                    if (clear_p)
                        state <= CLR;
                    else if (start_p) begin
                        state <= LOAD;
                        // Latched as LOAD is entered so the direction is
                        // already valid alongside the load pulse.
                        up_q  <= bus.dir_up_i;
                    end
                end
                LOAD: state <= RUN;
                RUN: begin
                    if (clear_p)
                        state <= CLR;
                    else if (start_p)
                        state <= PAUSE;
                    else if (bus.term_i) begin
                        state     <= DONE;
                        alarm_q   <= 1'b0;
                        blink_cnt <= '0;
                        tog_cnt   <= '0;
                    end
                end
                PAUSE: begin
                    if (clear_p)
                        state <= CLR;
                    else if (start_p)
                        state <= RUN;
                end
                DONE: begin
                    if (clear_p || start_p) begin
                        // Either key acknowledges the alarm.
                        state     <= CLR;
                        alarm_q   <= 1'b0;
                        blink_cnt <= '0;
                        tog_cnt   <= '0;
                    end else if (tog_cnt == TW'(ALARM_TOGGLES)) begin
                        alarm_q <= 1'b0;  // blink sequence finished, counters frozen
                    end else if (bus.tick_i) begin
                        if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                            blink_cnt <= '0;
                            alarm_q   <= ~alarm_q;
                            tog_cnt   <= tog_cnt + TW'(1);
                        end else begin
                            blink_cnt <= blink_cnt + BW'(1);
                        end
                    end
                end
                CLR: begin
                    state     <= IDLE;
                    alarm_q   <= 1'b0;
                    blink_cnt <= '0;
                    tog_cnt   <= '0;
                end
                default: state <= IDLE;  // unused codes 6/7
            endcase
        end
    end

    assign bus.timer_load_o = (state == LOAD) || (state == CLR);
    assign bus.timer_en_o   = (state == RUN);
    assign bus.done_o       = (state == DONE);
    assign bus.timer_up_o   = up_q;
    assign bus.alarm_o      = alarm_q;
    assign bus.state_o      = state;
endmodule

// File: doc/timer_run_ctrl.md
Name: timer_run_ctrl

Overview:
Run/pause/alarm sequencer for the BCD up/down timer datapath. It converts debounced start/stop and clear keys into timer load, enable and direction controls, and detects the terminal count. It also drives a blinking alarm on expiry. It sits between the debouncers and the timer in the board top level.

Parameters:
BLINK_TICKS, 4, number of tick_i pulses between alarm_o toggles (>=1)
ALARM_TOGGLES, 8, total alarm_o toggles after expiry before alarm_o is held low (even, >=2)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst  input  1  synchronous, active-high reset
start_stop_i  input  1  debounced start/stop key level, 1 = pressed
clear_i  input  1  debounced clear key level, 1 = pressed
dir_up_i  input  1  requested count direction, 1 = up (switch)
tick_i  input  1  one-cycle pulse per timer count step, from the timer prescaler
term_i  input  1  timer at terminal value; combinational decode of the timer count (all digits 0 counting down, all digits 9 counting up)
timer_load_o  output  1  load preset into timer, one cycle
timer_en_o  output  1  timer count enable
timer_up_o  output  1  latched count direction to timer
done_o  output  1  timer expired
alarm_o  output  1  blinking alarm indicator
state_o  output  3  current state code, for debug/LED

Behaviour:
- Edge detect: press pulses are start_p = start_stop_i & ~start_q and clear_p = clear_i & ~clear_q. start_q and clear_q are flops that reset to 1, so a key held through reset produces no pulse until it is released and pressed again.
- State codes: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4, CLR=5. Codes 6 and 7 go to IDLE on the next clock.
- Outputs are Moore-decoded from the registered state. Exceptions: alarm_o and timer_up_o are separate flops.
- Priority on each cycle: rst, then clear_p, then start_p, then term_i.
- IDLE: en=0, load=0. clear_p -> CLR. start_p -> LOAD.
- LOAD: timer_load_o=1 for exactly one cycle. timer_up_o <= dir_up_i on this clock. Next state is RUN unconditionally; presses in LOAD are ignored.
- RUN: timer_en_o=1. clear_p -> CLR. start_p -> PAUSE. Otherwise term_i=1 -> DONE. If the preset is already terminal, DONE follows on the first RUN cycle.
- PAUSE: en=0. clear_p -> CLR. start_p -> RUN. timer_up_o is unchanged.
- DONE: en=0, done_o=1.
  - Blink counter counts tick_i pulses. On reaching BLINK_TICKS it clears and toggles alarm_o.
  - Toggle counter increments per toggle. After ALARM_TOGGLES toggles, alarm_o is forced 0 and the counters freeze.
  - clear_p -> CLR. start_p -> CLR (acknowledge).
- CLR: timer_load_o=1 for one cycle, en=0. alarm_o, blink counter and toggle counter are cleared. Next state is IDLE.
- timer_up_o changes only in LOAD. dir_up_i changes during RUN/PAUSE/DONE have no effect.
- Latency: press sampled at edge N -> state updates at edge N -> load/en change visible in the cycle after edge N. term_i sampled in RUN at edge N -> timer_en_o low after edge N, so the timer stops one cycle later.
- On entering DONE, alarm_o=0 and counters=0. The first toggle to 1 occurs on the BLINK_TICKS-th tick.
- Reset (any state, mid-run included): state=IDLE, timer_load_o=0, timer_en_o=0, timer_up_o=0, done_o=0, alarm_o=0, all counters 0, start_q=clear_q=1.
- Counter widths: $clog2(BLINK_TICKS+1) and $clog2(ALARM_TOGGLES+1). No wrap occurs because both counters saturate or freeze.

Test Plan:
- Reset with held key: start_stop_i=1 held, rst=1 for 2 cycles then 0, key held 5 more cycles -> state_o=0 throughout, timer_load_o never 1; release then press -> LOAD on the next cycle.
- Start: dir_up_i=1, start_stop_i pulse 1 cycle in IDLE -> next cycle state_o=1, timer_load_o=1 for exactly 1 cycle, timer_up_o=1; following cycle state_o=2, timer_en_o=1.
- Pause/resume: in RUN press start -> state_o=3, timer_en_o=0; set dir_up_i=0 -> timer_up_o stays 1; press again -> state_o=2, timer_en_o=1.
- Expiry/alarm: BLINK_TICKS=2, ALARM_TOGGLES=4; in RUN assert term_i -> next cycle state_o=4, done_o=1, timer_en_o=0; feed 12 ticks -> alarm_o toggles at ticks 2,4,6,8 (1,0,1,0), then stays 0.
- Simultaneous: in RUN assert start and clear rising in the same cycle -> state_o=5 for 1 cycle with timer_load_o=1 and timer_en_o=0, then state_o=0 (not PAUSE).
- Reset mid-operation: in DONE with alarm_o=1, pulse rst 1 cycle -> next cycle state_o=0, alarm_o=0, done_o=0, timer_up_o=0; new start press runs the full LOAD->RUN sequence.
